// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the five-phase control sequencer.
// Phase bit indices match those used by the program counter.
package phase_sequencer_pkg;

    localparam int PH_F = 0;
    localparam int PH_R = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F    = 3'd1,
        S_R    = 3'd2,
        S_X    = 3'd3,
        S_M    = 3'd4,
        S_W    = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_e;

endpackage

// File: rtl/phase_sequencer_mem_wait_timer.sv
// Memory-ack wait counter shared by the fetch and data-memory phases.
// Raises timeout when the limit is reached and the ack is still low.
module mem_wait_timer #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic active,
    input  logic ack,
    output logic timeout
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (active && !ack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A same-cycle ack beats the limit, so ack gates the timeout.
    always_comb begin
        timeout = (WAIT_MAX != 0) && active && !ack
                  && (cnt_q == CW'(WAIT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle F/R/X/M/W control sequencer with memory handshakes,
// halt, run/stop, ack timeout and a retired-instruction counter.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             mem_op,
    input  logic             mem_we,
    input  logic             halt_req,
    output logic [4:0]       phase,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             wait_active, wait_ack, wait_clr, timeout;

    mem_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .active (wait_active),
        .ack    (wait_ack),
        .timeout(timeout)
    );

    always_comb begin
        wait_active = (state_q == S_F) || ((state_q == S_M) && mem_op);
        wait_ack    = (state_q == S_F) ? imem_ack : dmem_ack;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_F;
            S_F: begin
                if (imem_ack)     state_d = S_R;
                else if (timeout) state_d = S_ERR;
            end
            S_R: state_d = S_X;
            S_X: state_d = S_M;
            S_M: begin
                if (!mem_op || dmem_ack) state_d = S_W;
                else if (timeout)        state_d = S_ERR;
            end
            S_W: begin
                if (halt_req) state_d = S_HALT;
                else if (run) state_d = S_F;
                else          state_d = S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            S_ERR:  state_d = S_ERR;
        endcase
    end

    always_comb begin
        wait_clr  = ((state_d == S_F) || (state_d == S_M))
                    && (state_d != state_q);
        retired_d = retired_q;
        if (state_q == S_W) retired_d = retired_q + CNT_W'(1);
    end

    always_comb begin
        phase       = '0;
        phase[PH_F] = (state_q == S_F);
        phase[PH_R] = (state_q == S_R);
        phase[PH_X] = (state_q == S_X);
        phase[PH_M] = (state_q == S_M);
        phase[PH_W] = (state_q == S_W);
        imem_req    = (state_q == S_F);
        ir_we       = (state_q == S_F) && imem_ack;
        dmem_req    = (state_q == S_M) && mem_op;
        dmem_we     = (state_q == S_M) && mem_op && mem_we;
        halted      = (state_q == S_HALT);
        bus_err     = (state_q == S_ERR);
        retired     = retired_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multi-cycle control sequencer for the five-phase processor core.
- Generates the one-hot phase vector (F, R, X, M, W) consumed by the program counter, register file and ALU stages.
- Handshakes with instruction memory in F and with data memory in M, and stalls the phase advance until each memory acknowledges.
- Handles run/stop, the halt instruction, memory timeout, and counts retired instructions.

Parameters:
- WAIT_MAX, 255: maximum wait cycles for a memory ack before a bus error; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  one clock; reset is asynchronous and active-high
- run  in  1  level; 1 = fetch and execute, 0 = stop at the next instruction boundary
- imem_ack  in  1  instruction memory has valid data this cycle
- dmem_ack  in  1  data memory access completes this cycle
- mem_op  in  1  decoded instruction accesses data memory; stable R..W
- mem_we  in  1  decoded access is a store; stable R..W
- halt_req  in  1  decoded instruction is halt; stable R..W
- phase  out  5  one-hot phase: bit0=F, bit1=R, bit2=X, bit3=M, bit4=W
- imem_req  out  1  instruction fetch request
- ir_we  out  1  instruction register load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- halted  out  1  core stopped by halt instruction
- bus_err  out  1  memory timeout occurred (sticky)
- retired  out  CNT_W  count of completed instructions

Behaviour:
- States: IDLE, F, R, X, M, W, HALT, ERR.
  - State register is cleared asynchronously by rst.
  - All other registers update on posedge clk.
- Reset values:
  - State = IDLE; wait counter = 0; retired = 0.
  - All outputs = 0, phase = 5'b00000.
- Phase decode:
  - phase is one-hot in F/R/X/M/W, all-zero in IDLE/HALT/ERR.
  - Decoded combinationally from the state register; no extra latency.
- IDLE: go to F when run=1, otherwise stay.
- F:
  - imem_req=1 for the whole state.
  - ir_we = F & imem_ack (combinational, one cycle).
  - imem_ack=1 -> R; minimum F length is 1 cycle.
- R: exactly 1 cycle -> X.
- X: exactly 1 cycle -> M.
- M with mem_op=0: 1 cycle -> W; dmem_req=0.
- M with mem_op=1:
  - dmem_req=1 and dmem_we=mem_we while in M.
  - dmem_ack=1 -> W.
- W:
  - Exactly 1 cycle; the program counter commits on the W cycle, so W must never repeat or stretch.
  - retired increments by 1 on W, wrapping modulo 2^CNT_W.
  - Next state: halt_req=1 -> HALT; else run=1 -> F; else IDLE.
  - halt_req has priority over run.
- HALT: halted=1; stays in HALT until rst; run is ignored.
- Wait counter:
  - Clears on entry to F or M.
  - Increments each cycle in F, or in M with mem_op=1, while the ack is low.
  - When WAIT_MAX≠0 and counter == WAIT_MAX with ack still low -> ERR.
  - An ack arriving in the same cycle as the limit wins: normal advance, no error.
- ERR:
  - bus_err=1, all requests low; stays until rst.
  - bus_err is only cleared by rst.
- Ack handling:
  - imem_ack outside F and dmem_ack outside M (or in M with mem_op=0) are ignored.
  - Neither causes a state change nor an error.
- run deasserted mid-instruction: the instruction completes through W, then goes to IDLE; the fetch already in progress is not aborted.
- rst asserted mid-access:
  - Requests drop immediately (asynchronous), state goes to IDLE.
  - Any later stray ack is ignored.

Decomposition:
- Shared package holds:
  - Phase bit index constants PH_F=0, PH_R=1, PH_X=2, PH_M=3, PH_W=4 (same indices the program counter uses).
  - State enum encoding.
- One natural sub-module: mem_wait_timer.
  - Contains the clear/increment/limit compare, parameterised by WAIT_MAX.
  - Outputs a timeout pulse.
  - Instantiated once and shared by F and M, which are mutually exclusive.

Test Plan:
- Basic sequence: rst pulse, run=1, imem_ack=1 always, mem_op=0 -> phase sequence 00001,00010,00100,01000,10000 repeating; retired=1 after first W, 3 after three instructions.
- Fetch wait: imem_ack held low 3 cycles then high -> F lasts 4 cycles, ir_we high only in 4th cycle, phase==00001 throughout, then R.
- Store: mem_op=1, mem_we=1, dmem_ack after 2 cycles -> M lasts 3 cycles with dmem_req=1 and dmem_we=1, exactly one W cycle follows.
- Halt and stop:
  - halt_req=1 during one instruction -> after its W: halted=1, phase=0, retired frozen; run toggling has no effect.
  - With run dropped in X: W completes, state goes to IDLE; run=1 restarts at F.
- Timeout: WAIT_MAX=4, imem_ack never asserted -> ERR after 4 stall cycles, bus_err=1, imem_req=0, phase=0; ack exactly at the 4th cycle instead -> no error.
- Async reset: rst asserted mid-M with dmem_req=1 -> dmem_req and phase drop before the next clk edge, retired=0, stray dmem_ack afterwards ignored.
